// File: rtl/alu_exec_stage.sv
// Execute stage: one-cycle add/sub/and/or/slt and an optional iterative 1-bit/cycle shifter
// behind a valid/ready handshake with a registered result. Shifter is built when ALU_SHIFT_EN is defined.
module alu_exec_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            accept;
  logic            ld_en;
  logic [XLEN-1:0] ld_val;
  logic            ld_ill;

  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;

  assign accept = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_control)
      3'b000:  alu_res = a + b;
      3'b001:  alu_res = a - b;
      3'b010:  alu_res = a & b;
      3'b011:  alu_res = a | b;
      3'b101:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_SHIFT_EN
  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q;
  logic [XLEN-1:0]    sh_q;
  logic [XLEN-1:0]    sh_next;
  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         op_q;
  logic               is_shift;

  assign shamt    = b[SHAMT_W-1:0];
  assign is_shift = alu_control[2] && (alu_control[1:0] != 2'b01);
  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);

  // op_q holds alu_control[1:0]: 00 sll, 10 srl, 11 sra
  always_comb begin
    case (op_q)
      2'b00:   sh_next = {sh_q[XLEN-2:0], 1'b0};
      2'b10:   sh_next = {1'b0, sh_q[XLEN-1:1]};
      default: sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    ld_en  = 1'b0;
    ld_val = alu_res;
    ld_ill = alu_ill;
    if (state_q == StShift) begin
      // Last shift step loads the shifted value on the same edge
      ld_en  = (cnt_q == SHAMT_W'(1));
      ld_val = sh_next;
      ld_ill = 1'b0;
    end else if (accept) begin
      if (!is_shift) begin
        ld_en = 1'b1;
      end else if (shamt == '0) begin
        ld_en  = 1'b1;
        ld_val = a;
        ld_ill = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept && is_shift && (shamt != '0)) begin
            sh_q    <= a;
            cnt_q   <= shamt;
            op_q    <= alu_control[1:0];
            state_q <= StShift;
          end
        end
        StShift: begin
          sh_q  <= sh_next;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    ld_en  = accept;
    ld_val = alu_res;
    ld_ill = alu_ill;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
    end else if (ld_en) begin
      out_valid_q <= 1'b1;
      result_q    <= ld_ill ? '0 : ld_val;
      zero_q      <= ld_ill || (ld_val == '0);
      illegal_q   <= ld_ill;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed + randomized bench for alu_exec_stage; shift checks follow ALU_SHIFT_EN.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_pass  = 0;
  int n_total = 0;

  alu_exec_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model straight from the op definitions
  function automatic void model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(y[4:0]);
    r   = 32'd0;
    ill = 1'b0;
    lat = 1;
    case (c)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      3'd4: begin r = x << sh; lat = sh + 1; end
      3'd6: begin r = x >> sh; lat = sh + 1; end
      default: begin r = 32'($signed(x) >>> sh); lat = sh + 1; end
`else
      default: ill = 1'b1;
`endif
    endcase
  endfunction

  // Issue one op with out_ready=1 and check everything about its completion
  task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] x,
                       input logic [31:0] y);
    logic [31:0] er;
    logic        eill;
    int          elat;
    int          lat;
    int          busy;
    int          w;
    model(c, x, y, er, eill, elat);
    alu_control = c;
    a           = x;
    b           = y;
    in_valid    = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 1;
    busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, result, er);
    check({tag, ".zero"}, 32'(zero), (eill || er == 32'd0) ? 32'd1 : 32'd0);
    check({tag, ".illegal"}, 32'(illegal), 32'(eill));
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".busy"}, 32'(busy), 32'(elat - 1));
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    alu_control = 3'd0;
    a           = '0;
    b           = '0;
    out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.zero", 32'(zero), 32'd1);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // add wraps to zero
    do_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1);

    // slt then sub issued back to back
    alu_control = 3'b101; a = 32'hFFFF_FFFE; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b.slt_valid", 32'(out_valid), 32'd1);
    check("b2b.slt_result", result, 32'd1);
    check("b2b.in_ready", 32'(in_ready), 32'd1);
    alu_control = 3'b001; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b.sub_valid", 32'(out_valid), 32'd1);
    check("b2b.sub_result", result, 32'd0);
    check("b2b.sub_zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    check("b2b.drained", 32'(out_valid), 32'd0);

    // Backpressure: result held, next op refused until out_ready rises
    out_ready = 1'b0;
    alu_control = 3'b010; a = 32'd6; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_control = 3'b000; a = 32'd10; b = 32'd20;
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.result", result, 32'd2);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.next_valid", 32'(out_valid), 32'd1);
    check("bp.next_result", result, 32'd30);

`ifdef ALU_SHIFT_EN
    do_op("sra31", 3'b111, 32'h8000_0000, 32'd31);
    do_op("sll0", 3'b100, 32'd1, 32'd0);
    // Reset in the middle of a shift drops it
    alu_control = 3'b110; a = 32'hF0; b = 32'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (out_valid) seen++;
        @(posedge clk); #1;
      end
      check("midrst.no_stale", 32'(seen), 32'd0);
    end
`else
    do_op("srl_off", 3'b110, 32'h10, 32'd1);
`endif

    for (int i = 0; i < 40; i++) begin
      do_op("rand", 3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
